tx_meta_arbiter: RTL and testbench

TX_META_ARBITER -- requirements
Module: tx_meta_arbiter

---
 rtl/tx_meta_arbiter_pkg.sv | 20 ++
 rtl/tx_meta_arbiter_fifo.sv | 62 ++++++
 rtl/tx_meta_arbiter.sv | 90 +++++++++
 tb/tb_tx_meta_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_meta_arbiter_pkg.sv
// Shared TX metadata types and packet flag constants used by the TX metadata
// arbiter and its output FIFO.
package tx_meta_arbiter_pkg;

    typedef logic [3:0] pkt_flags_t;

    localparam pkt_flags_t PKT_PCIE = 4'h1;
    localparam pkt_flags_t PKT_DROP = 4'h8;

    typedef struct packed {
        logic [15:0] pkt_queue_id;
        logic [31:0] hash;
        pkt_flags_t  pkt_flags;
    } metadata_t;

    function automatic logic is_drop(input metadata_t meta);
        return meta.pkt_flags == PKT_DROP;
    endfunction

endpackage

// File: rtl/tx_meta_arbiter_fifo.sv
// meta_skid_fifo: 2-entry valid/ready FIFO, generic over the stored data type.
// entry0 is always the head; push_ready reflects only the registered occupancy.
module meta_skid_fifo #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  T     push_data,
    input  logic push_valid,
    output logic push_ready,
    output T     pop_data,
    output logic pop_valid,
    input  logic pop_ready
);

    T           entry0;
    T           entry1;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    assign pop_data   = entry0;
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_ready && pop_valid;

    // A push lands in the first free slot after any pop has shifted entry1 forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= push_data;
                    end else begin
                        entry1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/tx_meta_arbiter.sv
// Merges NB_PORTS TX metadata streams (round-robin or fixed priority) into one
// 2-entry output FIFO. Define TX_META_ARB_STATS_EN for forwarded/dropped counters.
module tx_meta_arbiter
    import tx_meta_arbiter_pkg::*;
#(
    parameter int NB_PORTS = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef TX_META_ARB_STATS_EN
    output logic [31:0]         nb_fwd_pkts,
    output logic [31:0]         nb_drop_pkts,
`endif
    input  metadata_t           in_meta_data [NB_PORTS],
    input  logic [NB_PORTS-1:0] in_meta_valid,
    output logic [NB_PORTS-1:0] in_meta_ready,
    output metadata_t           out_meta_data,
    output logic                out_meta_valid,
    input  logic                out_meta_ready,
    input  logic                enable_rr
);

    localparam int PTR_W = $clog2(NB_PORTS);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] cand;
    logic             sel_found;
    logic             fifo_space;
    logic             accept;
    logic             beat_drop;
    logic             fifo_push;

    // Search starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NB_PORTS; k++) begin
            cand = enable_rr ? PTR_W'(rr_ptr + PTR_W'(k)) : PTR_W'(k);
            if (!sel_found && in_meta_valid[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign accept        = sel_found && fifo_space && !rst;
    assign in_meta_ready = accept ? (NB_PORTS'(1) << sel) : '0;
    assign beat_drop     = is_drop(in_meta_data[sel]);
    assign fifo_push     = accept && !beat_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept && enable_rr) begin
            rr_ptr <= sel + PTR_W'(1);
        end
    end

    meta_skid_fifo #(
        .T (metadata_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_data  (in_meta_data[sel]),
        .push_valid (fifo_push),
        .push_ready (fifo_space),
        .pop_data   (out_meta_data),
        .pop_valid  (out_meta_valid),
        .pop_ready  (out_meta_ready)
    );

`ifdef TX_META_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nb_fwd_pkts  <= '0;
            nb_drop_pkts <= '0;
        end else begin
            if (fifo_push) begin
                nb_fwd_pkts <= nb_fwd_pkts + 32'd1;
            end
            if (accept && beat_drop) begin
                nb_drop_pkts <= nb_drop_pkts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_meta_arbiter.sv
// Self-checking bench for tx_meta_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_tx_meta_arbiter;
    import tx_meta_arbiter_pkg::*;

    localparam int NB = 4;

    logic          clk;
    logic          rst;
    metadata_t     in_meta_data [NB];
    logic [NB-1:0] in_meta_valid;
    logic [NB-1:0] in_meta_ready;
    metadata_t     out_meta_data;
    logic          out_meta_valid;
    logic          out_meta_ready;
    logic          enable_rr;
`ifdef TX_META_ARB_STATS_EN
    logic [31:0]   nb_fwd_pkts;
    logic [31:0]   nb_drop_pkts;
`endif

    tx_meta_arbiter #(.NB_PORTS(NB)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef TX_META_ARB_STATS_EN
        .nb_fwd_pkts    (nb_fwd_pkts),
        .nb_drop_pkts   (nb_drop_pkts),
`endif
        .in_meta_data   (in_meta_data),
        .in_meta_valid  (in_meta_valid),
        .in_meta_ready  (in_meta_ready),
        .out_meta_data  (out_meta_data),
        .out_meta_valid (out_meta_valid),
        .out_meta_ready (out_meta_ready),
        .enable_rr      (enable_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: output FIFO as a queue, pointer as a plain integer.
    metadata_t   model_q[$];
    int          model_rr   = 0;
    int unsigned model_fwd  = 0;
    int unsigned model_drop = 0;
    metadata_t   src_q [NB][$];
    int          obs_grant;
    int          model_g;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic metadata_t make_beat(input int src, input int seq, input pkt_flags_t flags);
        metadata_t m;
        m.pkt_queue_id = {src[7:0], seq[7:0]};
        m.hash         = $urandom;
        m.pkt_flags    = flags;
        return m;
    endfunction

    function automatic int grant_of(input logic [NB-1:0] r);
        int g = -1;
        int n = 0;
        for (int i = 0; i < NB; i++) begin
            if (r[i]) begin
                n++;
                if (g < 0) g = i;
            end
        end
        return (n > 1) ? -2 : g;
    endfunction

    function automatic int model_grant();
        int g = -1;
        if (model_q.size() < 2) begin
            for (int k = 0; k < NB; k++) begin
                int idx = enable_rr ? (model_rr + k) % NB : k;
                if (g < 0 && in_meta_valid[idx]) g = idx;
            end
        end
        return g;
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < NB; i++) begin
            in_meta_valid[i] = (src_q[i].size() != 0);
            in_meta_data[i]  = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic drive_all(input logic [NB-1:0] valid, input int seq);
        for (int i = 0; i < NB; i++) begin
            in_meta_valid[i] = valid[i];
            in_meta_data[i]  = make_beat(i, seq, PKT_PCIE);
        end
    endtask

    // Called at a falling edge with inputs settled; returns at the next falling edge.
    task automatic run_cycle();
        logic [NB-1:0] exp_ready;
        model_g   = model_grant();
        exp_ready = (model_g >= 0) ? (NB'(1) << model_g) : '0;
        #1;
        obs_grant = grant_of(in_meta_ready);
        checkOutput("in_meta_ready", 64'(in_meta_ready), 64'(exp_ready));
        checkOutput("out_meta_valid", 64'(out_meta_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0)
            checkOutput("out_meta_data", 64'(out_meta_data), 64'(model_q[0]));
`ifdef TX_META_ARB_STATS_EN
        checkOutput("nb_fwd_pkts", 64'(nb_fwd_pkts), 64'(model_fwd));
        checkOutput("nb_drop_pkts", 64'(nb_drop_pkts), 64'(model_drop));
`endif
        if (out_meta_ready && model_q.size() != 0) void'(model_q.pop_front());
        if (model_g >= 0) begin
            if (in_meta_data[model_g].pkt_flags == PKT_DROP) begin
                model_drop++;
            end else begin
                model_q.push_back(in_meta_data[model_g]);
                model_fwd++;
            end
            if (enable_rr) model_rr = (model_g + 1) % NB;
            if (src_q[model_g].size() != 0) void'(src_q[model_g].pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        in_meta_valid  = '0;
        out_meta_ready = 1'b1;
        repeat (n) run_cycle();
    endtask

    initial begin
        int        exp_seq [5] = '{1, 1, 1, 3, 3};
        int        accepts;
        int        out_beats;
        metadata_t b0, b1, pcie_beat, seen;

        rst            = 1'b1;
        enable_rr      = 1'b1;
        out_meta_ready = 1'b1;
        drive_all('1, 0);
        #2;
        checkOutput("reset_ready", 64'(in_meta_ready), 64'(0));
        checkOutput("reset_valid", 64'(out_meta_valid), 64'(0));
`ifdef TX_META_ARB_STATS_EN
        checkOutput("reset_fwd", 64'(nb_fwd_pkts), 64'(0));
        checkOutput("reset_drop", 64'(nb_drop_pkts), 64'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] round-robin, all sources valid");
        for (int c = 0; c < 5; c++) begin
            drive_all('1, c + 1);
            run_cycle();
            checkOutput("rr_grant", 64'(obs_grant), 64'(c % NB));
        end
        drain(2);

        $display("[TB] fixed priority, sources 1 and 3");
        enable_rr = 1'b0;
        for (int s = 0; s < 3; s++) src_q[1].push_back(make_beat(1, s, PKT_PCIE));
        for (int s = 0; s < 2; s++) src_q[3].push_back(make_beat(3, s, PKT_PCIE));
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            run_cycle();
            checkOutput("fp_grant", 64'(obs_grant), 64'(exp_seq[c]));
        end
        drain(2);
        enable_rr = 1'b1;
        drive_all('1, 40);
        run_cycle();
        checkOutput("rr_ptr_held", 64'(obs_grant), 64'(1));
        drain(2);

        $display("[TB] downstream stall");
        enable_rr      = 1'b0;
        out_meta_ready = 1'b0;
        b0 = make_beat(0, 0, PKT_PCIE);
        b1 = make_beat(0, 1, PKT_PCIE);
        src_q[0].push_back(b0);
        src_q[0].push_back(b1);
        src_q[0].push_back(make_beat(0, 2, PKT_PCIE));
        accepts = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            run_cycle();
            if (obs_grant == 0) accepts++;
        end
        checkOutput("stall_accepts", 64'(accepts), 64'(2));
        checkOutput("stall_ready", 64'(in_meta_ready), 64'(0));
        out_meta_ready = 1'b1;
        applyStimulus();
        #1 checkOutput("stall_first", 64'(out_meta_data), 64'(b0));
        run_cycle();
        applyStimulus();
        #1 checkOutput("stall_second", 64'(out_meta_data), 64'(b1));
        run_cycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            run_cycle();
        end
        drain(1);

        $display("[TB] drop then forward on source 2");
        enable_rr = 1'b1;
        pcie_beat = make_beat(2, 1, PKT_PCIE);
        src_q[2].push_back(make_beat(2, 0, PKT_DROP));
        src_q[2].push_back(pcie_beat);
        out_beats = 0;
        seen      = '0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            #1;
            if (out_meta_valid) begin
                out_beats++;
                seen = out_meta_data;
            end
            #1;
            run_cycle();
        end
        checkOutput("drop_out_beats", 64'(out_beats), 64'(1));
        checkOutput("drop_out_data", 64'(seen), 64'(pcie_beat));
`ifdef TX_META_ARB_STATS_EN
        checkOutput("drop_stat", 64'(nb_drop_pkts), 64'(1));
        checkOutput("fwd_stat", 64'(nb_fwd_pkts), 64'(model_fwd));
`endif

        $display("[TB] pointer wrap from 3");
        drive_all(4'b0001, 50);
        run_cycle();
        checkOutput("wrap_grant", 64'(obs_grant), 64'(0));
        drive_all('1, 51);
        run_cycle();
        checkOutput("wrap_ptr", 64'(obs_grant), 64'(1));
        drain(2);

        $display("[TB] reset while full");
        out_meta_ready = 1'b0;
        src_q[0].push_back(make_beat(0, 60, PKT_PCIE));
        src_q[0].push_back(make_beat(0, 61, PKT_PCIE));
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            run_cycle();
        end
        checkOutput("full_before_reset", 64'(out_meta_valid), 64'(1));
        drive_all('1, 62);
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_mid_valid", 64'(out_meta_valid), 64'(0));
        checkOutput("reset_mid_ready", 64'(in_meta_ready), 64'(0));
        model_q.delete();
        model_rr   = 0;
        model_fwd  = 0;
        model_drop = 0;
        @(negedge clk);
`ifdef TX_META_ARB_STATS_EN
        checkOutput("reset_mid_fwd", 64'(nb_fwd_pkts), 64'(0));
`endif
        rst            = 1'b0;
        out_meta_ready = 1'b1;
        drive_all(4'b1100, 63);
        run_cycle();
        checkOutput("post_reset_grant", 64'(obs_grant), 64'(2));
        drain(2);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) enable_rr = $urandom_range(0, 1) != 0;
            out_meta_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < NB; i++) begin
                int r = $urandom_range(0, 7);
                in_meta_valid[i] = $urandom_range(0, 1) != 0;
                in_meta_data[i]  = make_beat(i, c, (r == 0) ? PKT_DROP :
                                             (r == 1) ? pkt_flags_t'($urandom_range(0, 15)) : PKT_PCIE);
            end
            run_cycle();
        end
        drain(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
